// File: rtl/ipb_io_regbank.sv
// ipb_io_regbank: IPbus register bank fed by the IO handshake stage (rd_en level, wr_en pulse).
// Optional build macro IPB_IO_REGBANK_STATUS_SYNC_EN adds 2-flop synchronisers on status_in.
module ipb_io_regbank #(
   parameter int unsigned RD_LATENCY = 2,
   parameter logic [31:0] ID_VALUE   = 32'h5746_4435
) (
   input  logic         clk,
   input  logic         res,
   input  logic         io_rd_en,
   input  logic         io_wr_en,
   input  logic [31:0]  ipb_addr,
   input  logic [31:0]  ipb_wdata,
   output logic [31:0]  ipb_rdata,
   output logic         io_rd_ack,
   output logic [31:0]  ctrl_out,
   output logic [31:0]  pulse_out,
   input  logic [127:0] status_in,
   output logic [15:0]  bad_addr_cnt
);

   localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_ACK  = 2'd2,
      RD_HOLD = 2'd3
   } rd_state_t;

   rd_state_t   state_reg, state_next;
   logic [3:0]  lat_cnt_reg, lat_cnt_next;
   logic [31:0] scratch_reg;
   logic [31:0] ctrl_reg;
   logic [31:0] pulse_reg;
   logic [31:0] rdata_reg;
   logic        ack_reg;
   logic [15:0] bad_cnt_reg, bad_cnt_next;

   logic [3:0]        addr_idx;
   logic              addr_unmapped;
   logic              rd_load;
   logic [31:0]       rdata_mux;
   logic [3:0][31:0]  status_word;
   logic [16:0]       bad_sum;
   logic              addr_high_unused;

   assign addr_idx         = ipb_addr[3:0];
   assign addr_unmapped    = (addr_idx > 4'h8);
   assign addr_high_unused = ^ipb_addr[31:4];

   // Status words as seen by the read decode
`ifdef IPB_IO_REGBANK_STATUS_SYNC_EN
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_status_sync
         logic [31:0] meta_reg;
         logic [31:0] sync_reg;
         always_ff @(posedge clk) begin
            if (res) begin
               meta_reg <= 32'h0;
               sync_reg <= 32'h0;
            end else begin
               meta_reg <= status_in[32*gi +: 32];
               sync_reg <= meta_reg;
            end
         end
         assign status_word[gi] = sync_reg;
      end
   endgenerate
`else
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_status_direct
         assign status_word[gi] = status_in[32*gi +: 32];
      end
   endgenerate
`endif

   // Read decode uses register values before any same-cycle write lands
   always_comb begin
      rdata_mux = 32'hDEAD_BEEF;
      case (addr_idx)
         4'h0:                      rdata_mux = ID_VALUE;
         4'h1:                      rdata_mux = scratch_reg;
         4'h2:                      rdata_mux = ctrl_reg;
         4'h3:                      rdata_mux = 32'h0;
         4'h4, 4'h5, 4'h6, 4'h7:    rdata_mux = status_word[addr_idx[1:0]];
         4'h8:                      rdata_mux = {16'h0, bad_cnt_reg};
         default:                   rdata_mux = 32'hDEAD_BEEF;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      lat_cnt_next = lat_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (io_rd_en) begin
               if (RD_LATENCY <= 1) begin
                  state_next = RD_ACK;
               end else begin
                  state_next   = RD_WAIT;
                  lat_cnt_next = LAT_LOAD;
               end
            end
         end
         RD_WAIT: begin
            if (!io_rd_en) begin
               state_next = IDLE;
            end else begin
               lat_cnt_next = lat_cnt_reg - 4'd1;
               if (lat_cnt_reg == 4'd1) begin
                  state_next = RD_ACK;
               end
            end
         end
         RD_ACK: begin
            state_next = RD_HOLD;
         end
         RD_HOLD: begin
            if (!io_rd_en) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // RD_ACK is only reachable from IDLE or RD_WAIT, so this marks the entry edge
   assign rd_load = (state_next == RD_ACK);

   always_comb begin
      bad_sum = {1'b0, bad_cnt_reg}
              + 17'(io_wr_en & addr_unmapped)
              + 17'(rd_load & addr_unmapped);
      bad_cnt_next = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_reg   <= IDLE;
         lat_cnt_reg <= 4'd0;
         rdata_reg   <= 32'h0;
         ack_reg     <= 1'b0;
         bad_cnt_reg <= 16'h0;
      end else begin
         state_reg   <= state_next;
         lat_cnt_reg <= lat_cnt_next;
         ack_reg     <= rd_load;
         bad_cnt_reg <= bad_cnt_next;
         if (rd_load) begin
            rdata_reg <= rdata_mux;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         scratch_reg <= 32'h0;
         ctrl_reg    <= 32'h0;
         pulse_reg   <= 32'h0;
      end else begin
         pulse_reg <= 32'h0;
         if (io_wr_en) begin
            case (addr_idx)
               4'h1:    scratch_reg <= ipb_wdata;
               4'h2:    ctrl_reg    <= ipb_wdata;
               4'h3:    pulse_reg   <= ipb_wdata;
               default: ;
            endcase
         end
      end
   end

   assign ipb_rdata    = rdata_reg;
   assign io_rd_ack    = ack_reg;
   assign ctrl_out     = ctrl_reg;
   assign pulse_out    = pulse_reg;
   assign bad_addr_cnt = bad_cnt_reg;

endmodule

// File: tb/tb_ipb_io_regbank.sv
// Self-checking bench for ipb_io_regbank: directed vector table, hand-built corner
// sequences and a randomized phase checked against a transaction-level register model.
module tb_ipb_io_regbank;

   localparam int          RD_LAT = 2;
   localparam logic [31:0] ID_VAL = 32'h5746_4435;

   logic         clk = 1'b0;
   logic         res;
   logic         io_rd_en;
   logic         io_wr_en;
   logic [31:0]  ipb_addr;
   logic [31:0]  ipb_wdata;
   logic [31:0]  ipb_rdata;
   logic         io_rd_ack;
   logic [31:0]  ctrl_out;
   logic [31:0]  pulse_out;
   logic [127:0] status_in;
   logic [15:0]  bad_addr_cnt;

   always #5 clk = ~clk;

   ipb_io_regbank #(
      .RD_LATENCY (RD_LAT),
      .ID_VALUE   (ID_VAL)
   ) dut (
      .clk          (clk),
      .res          (res),
      .io_rd_en     (io_rd_en),
      .io_wr_en     (io_wr_en),
      .ipb_addr     (ipb_addr),
      .ipb_wdata    (ipb_wdata),
      .ipb_rdata    (ipb_rdata),
      .io_rd_ack    (io_rd_ack),
      .ctrl_out     (ctrl_out),
      .pulse_out    (pulse_out),
      .status_in    (status_in),
      .bad_addr_cnt (bad_addr_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Transaction-level model of the register map
   logic [31:0] m_scratch;
   logic [31:0] m_ctrl;
   int          m_bad;
   logic [31:0] m_status [4];

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int k;
      k = int'(a[3:0]);
      if (k == 0) return ID_VAL;
      if (k == 1) return m_scratch;
      if (k == 2) return m_ctrl;
      if (k == 3) return 32'h0;
      if (k <= 7) return m_status[k-4];
      if (k == 8) return 32'(m_bad);
      return 32'hDEAD_BEEF;
   endfunction

   function automatic bit m_unmapped(input logic [31:0] a);
      return int'(a[3:0]) > 8;
   endfunction

   task automatic m_bump();
      if (m_bad < 65535) m_bad = m_bad + 1;
   endtask

   task automatic m_write(input logic [31:0] a, input logic [31:0] d);
      if (a[3:0] == 4'h1) m_scratch = d;
      else if (a[3:0] == 4'h2) m_ctrl = d;
      else if (m_unmapped(a)) m_bump();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] data,
                          output logic second_ack);
      ipb_addr = a;
      io_rd_en = 1'b1;
      lat = 0;
      do begin
         step();
         lat++;
      end while (io_rd_ack !== 1'b1 && lat < 40);
      data = ipb_rdata;
      step();
      second_ack = io_rd_ack;
      io_rd_en = 1'b0;
      step();
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] ctrl_seen, output logic [31:0] pulse_seen,
                           output logic [31:0] pulse_after, output logic [15:0] bad_seen);
      ipb_addr  = a;
      ipb_wdata = d;
      io_wr_en  = 1'b1;
      step();
      io_wr_en    = 1'b0;
      ctrl_seen   = ctrl_out;
      pulse_seen  = pulse_out;
      bad_seen    = bad_addr_cnt;
      step();
      pulse_after = pulse_out;
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;   // read data, or ctrl_out after a write
      logic [31:0] exp_pulse;
      logic [15:0] exp_bad;
   } vec_t;

   vec_t vecs[16];

   int          lat;
   logic [31:0] data;
   logic        sa;
   logic [31:0] c_seen, p_seen, p_after;
   logic [15:0] b_seen;
   logic        ack_seen;
   logic [31:0] a, d, e;
   int          op;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          ID_VAL,        32'h0,  16'd0};
      vecs[1]  = '{1'b1, 32'h0000_0002, 32'hA5A5_0001,  32'hA5A5_0001, 32'h0,  16'd0};
      vecs[2]  = '{1'b0, 32'h0000_0002, 32'h0,          32'hA5A5_0001, 32'h0,  16'd0};
      vecs[3]  = '{1'b1, 32'h0000_0003, 32'h0000_0081,  32'hA5A5_0001, 32'h81, 16'd0};
      vecs[4]  = '{1'b0, 32'h0000_0003, 32'h0,          32'h0,         32'h0,  16'd0};
      vecs[5]  = '{1'b0, 32'h0000_000C, 32'h0,          32'hDEAD_BEEF, 32'h0,  16'd1};
      vecs[6]  = '{1'b1, 32'h0000_000F, 32'h1234_5678,  32'hA5A5_0001, 32'h0,  16'd2};
      vecs[7]  = '{1'b0, 32'h0000_0008, 32'h0,          32'h0000_0002, 32'h0,  16'd2};
      vecs[8]  = '{1'b1, 32'h0000_0001, 32'hCAFE_F00D,  32'hA5A5_0001, 32'h0,  16'd2};
      vecs[9]  = '{1'b0, 32'h0000_0001, 32'h0,          32'hCAFE_F00D, 32'h0,  16'd2};
      vecs[10] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF,  32'hA5A5_0001, 32'h0,  16'd2};
      vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,          ID_VAL,        32'h0,  16'd2};
      vecs[12] = '{1'b0, 32'hABCD_0002, 32'h0,          32'hA5A5_0001, 32'h0,  16'd2};
      vecs[13] = '{1'b0, 32'h0000_0005, 32'h0,          32'h2222_0001, 32'h0,  16'd2};
      vecs[14] = '{1'b1, 32'h0000_0005, 32'h0,          32'hA5A5_0001, 32'h0,  16'd2};
      vecs[15] = '{1'b0, 32'h0000_0005, 32'h0,          32'h2222_0001, 32'h0,  16'd2};

      res       = 1'b1;
      io_rd_en  = 1'b0;
      io_wr_en  = 1'b0;
      ipb_addr  = 32'h0;
      ipb_wdata = 32'h0;
      status_in = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
      repeat (4) step();
      res = 1'b0;
      step();

      chk("reset_ack",   {31'h0, io_rd_ack}, 32'h0);
      chk("reset_rdata", ipb_rdata, 32'h0);
      chk("reset_ctrl",  ctrl_out, 32'h0);
      chk("reset_pulse", pulse_out, 32'h0);
      chk("reset_bad",   {16'h0, bad_addr_cnt}, 32'h0);

      // Directed vector table
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].wdata, c_seen, p_seen, p_after, b_seen);
            $display("vec %0d wr addr=%h data=%h ctrl=%h pulse=%h bad=%0d",
                     i, vecs[i].addr, vecs[i].wdata, c_seen, p_seen, b_seen);
            chk("vec_ctrl", c_seen, vecs[i].exp_data);
            chk("vec_pulse", p_seen, vecs[i].exp_pulse);
            chk("vec_pulse_clear", p_after, 32'h0);
            chk("vec_wr_bad", {16'h0, b_seen}, {16'h0, vecs[i].exp_bad});
         end else begin
            do_read(vecs[i].addr, lat, data, sa);
            $display("vec %0d rd addr=%h data=%h lat=%0d bad=%0d",
                     i, vecs[i].addr, data, lat, bad_addr_cnt);
            chk("vec_rd_latency", 32'(lat), 32'(RD_LAT));
            chk("vec_rdata", data, vecs[i].exp_data);
            chk("vec_second_ack", {31'h0, sa}, 32'h0);
            chk("vec_rd_bad", {16'h0, bad_addr_cnt}, {16'h0, vecs[i].exp_bad});
         end
      end

      // Abort: rd_en drops one cycle after rising, unmapped address
      ack_seen = 1'b0;
      ipb_addr = 32'h0000_000A;
      io_rd_en = 1'b1;
      step();
      ack_seen |= io_rd_ack;
      io_rd_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         ack_seen |= io_rd_ack;
      end
      $display("abort addr=%h ack_seen=%0d rdata=%h bad=%0d", ipb_addr, ack_seen, ipb_rdata, bad_addr_cnt);
      chk("abort_no_ack", {31'h0, ack_seen}, 32'h0);
      chk("abort_rdata_kept", ipb_rdata, 32'h2222_0001);
      chk("abort_no_count", {16'h0, bad_addr_cnt}, 32'h2);

      // Reset while in RD_WAIT
      do_write(32'h1, 32'h0000_0055, c_seen, p_seen, p_after, b_seen);
      do_write(32'h2, 32'h0000_0077, c_seen, p_seen, p_after, b_seen);
      ack_seen = 1'b0;
      ipb_addr = 32'h1;
      io_rd_en = 1'b1;
      step();
      ack_seen |= io_rd_ack;
      res = 1'b1;
      step();
      res = 1'b0;
      io_rd_en = 1'b0;
      chk("midres_ack",   {31'h0, io_rd_ack}, 32'h0);
      chk("midres_rdata", ipb_rdata, 32'h0);
      chk("midres_ctrl",  ctrl_out, 32'h0);
      chk("midres_pulse", pulse_out, 32'h0);
      chk("midres_bad",   {16'h0, bad_addr_cnt}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         ack_seen |= io_rd_ack;
      end
      $display("midreset ack_seen=%0d", ack_seen);
      chk("midres_no_ack", {31'h0, ack_seen}, 32'h0);
      do_read(32'h1, lat, data, sa);
      $display("rd addr=%h data=%h lat=%0d", 32'h1, data, lat);
      chk("midres_scratch", data, 32'h0);

      m_scratch = 32'h0;
      m_ctrl    = 32'h0;
      m_bad     = 0;
      for (int k = 0; k < 4; k++) m_status[k] = status_in[32*k +: 32];

      // Write to scratch in the same cycle the read loads: read sees the old value
      do_write(32'h1, 32'h1111_1111, c_seen, p_seen, p_after, b_seen);
      m_write(32'h1, 32'h1111_1111);
      ipb_addr = 32'h1;
      io_rd_en = 1'b1;
      step();
      io_wr_en  = 1'b1;
      ipb_wdata = 32'h2222_2222;
      step();
      io_wr_en = 1'b0;
      $display("collide ack=%0d rdata=%h", io_rd_ack, ipb_rdata);
      chk("collide_ack", {31'h0, io_rd_ack}, 32'h1);
      chk("collide_old_value", ipb_rdata, 32'h1111_1111);
      step();
      io_rd_en = 1'b0;
      step();
      m_write(32'h1, 32'h2222_2222);
      do_read(32'h1, lat, data, sa);
      $display("rd addr=%h data=%h lat=%0d", 32'h1, data, lat);
      chk("collide_new_value", data, m_read(32'h1));

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 9);
         a  = $urandom;
         d  = $urandom;
         if (op < 4) begin
            do_write(a, d, c_seen, p_seen, p_after, b_seen);
            m_write(a, d);
            $display("rand %0d wr addr=%h data=%h ctrl=%h pulse=%h bad=%0d", i, a, d, c_seen, p_seen, b_seen);
            chk("rand_ctrl", c_seen, m_ctrl);
            chk("rand_pulse", p_seen, (a[3:0] == 4'h3) ? d : 32'h0);
            chk("rand_pulse_clear", p_after, 32'h0);
            chk("rand_wr_bad", {16'h0, b_seen}, 32'(m_bad));
         end else if (op < 9) begin
            e = m_read(a);
            do_read(a, lat, data, sa);
            if (m_unmapped(a)) m_bump();
            $display("rand %0d rd addr=%h data=%h lat=%0d bad=%0d", i, a, data, lat, bad_addr_cnt);
            chk("rand_rd_latency", 32'(lat), 32'(RD_LAT));
            chk("rand_rdata", data, e);
            chk("rand_second_ack", {31'h0, sa}, 32'h0);
            chk("rand_rd_bad", {16'h0, bad_addr_cnt}, 32'(m_bad));
         end else begin
            for (int k = 0; k < 4; k++) begin
               m_status[k] = $urandom;
               status_in[32*k +: 32] = m_status[k];
            end
            $display("rand %0d status update %h", i, status_in);
            repeat (3) step();
         end
      end

      // Saturation of the unmapped-access counter
      res = 1'b1;
      step();
      res = 1'b0;
      ipb_addr  = 32'h9;
      ipb_wdata = 32'h0;
      io_wr_en  = 1'b1;
      repeat (65533) step();
      io_wr_en = 1'b0;
      $display("preload bad=%0d", bad_addr_cnt);
      chk("sat_preload", {16'h0, bad_addr_cnt}, 32'd65533);
      for (int r = 0; r < 2; r++) begin
         ipb_addr = 32'h9;
         io_rd_en = 1'b1;
         step();
         io_wr_en = 1'b1;
         step();
         io_wr_en = 1'b0;
         $display("sat pass %0d ack=%0d rdata=%h bad=%0d", r, io_rd_ack, ipb_rdata, bad_addr_cnt);
         chk("sat_ack", {31'h0, io_rd_ack}, 32'h1);
         chk("sat_rdata", ipb_rdata, 32'hDEAD_BEEF);
         chk("sat_bad", {16'h0, bad_addr_cnt}, 32'h0000_FFFF);
         step();
         io_rd_en = 1'b0;
         step();
      end
      do_read(32'h8, lat, data, sa);
      $display("rd addr=%h data=%h lat=%0d", 32'h8, data, lat);
      chk("sat_readback", data, 32'h0000_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ipb_io_regbank.md
# ipb_io_regbank

Register bank directly downstream of the IPbus IO handshake stage. Consumes its `io_rd_en` level and `io_wr_en` pulse, decodes the IPbus address, and performs register writes. Returns read data with an `io_rd_ack` pulse after a fixed, parameterised latency. Provides control/pulse outputs and status readback for the rest of the WFD5 fabric.

## Interface
- `RD_LATENCY`, default 2: cycles from the first `io_rd_en` high cycle to `io_rd_ack`. Legal range 1..15.
- `ID_VALUE`, default 32'h5746_4435: constant returned by the ID register.
- `clk`  in  1  IPbus clock.
- `res`  in  1  global reset, synchronous, active-high.
- `io_rd_en`  in  1  read enable level, held high for the whole read operation.
- `io_wr_en`  in  1  one-cycle write strobe.
- `ipb_addr`  in  32  IPbus address; only bits [3:0] are decoded, bits [31:4] are ignored.
- `ipb_wdata`  in  32  write data, valid while `io_wr_en` is high.
- `ipb_rdata`  out  32  read data.
- `io_rd_ack`  out  1  one-cycle read acknowledge.
- `ctrl_out`  out  32  control register contents.
- `pulse_out`  out  32  one-cycle pulses.
- `status_in`  in  4×32 (128, word k at [32k+31:32k])  status words.
- `bad_addr_cnt`  out  16  saturating count of unmapped accesses.

## Operation
- Register map, indexed by `ipb_addr[3:0]`:
  - 0x0 ID: RO, reads `ID_VALUE`.
  - 0x1 scratch: RW.
  - 0x2 ctrl: RW, drives `ctrl_out`.
  - 0x3 pulse: WO, reads 0.
  - 0x4–0x7 status k = addr−4: RO.
  - 0x8 `{16'h0, bad_addr_cnt}`: RO.
  - 0x9–0xF unmapped: reads 32'hDEAD_BEEF, writes ignored.
- Writes to RO addresses are ignored and are not counted as unmapped.
- Write: on a cycle with `io_wr_en`=1, the target register updates at that edge. A pulse write drives `pulse_out`=`ipb_wdata` for exactly the next cycle, then 0.
- Read FSM states: IDLE, RD_WAIT, RD_ACK, RD_HOLD.
  - IDLE: `io_rd_en`=1 → load latency counter with `RD_LATENCY`−1 and go to RD_WAIT. If `RD_LATENCY`=1, go directly to RD_ACK.
  - RD_WAIT: decrement the counter; at 0 go to RD_ACK.
  - RD_ACK: `io_rd_ack`=1 for one cycle. `ipb_rdata` is loaded at the edge entering RD_ACK from the address sampled that cycle. Next state is RD_HOLD.
  - RD_HOLD: wait for `io_rd_en`=0, then go to IDLE. No second ack is issued for the same operation.
  - `io_rd_en` falling in RD_WAIT (abort): go to IDLE with no ack, `ipb_rdata` unchanged, no count.
- `bad_addr_cnt` increments by 1:
  - on a write to an unmapped address;
  - on entry to RD_ACK for an unmapped read.
  - It saturates at 16'hFFFF.
  - If a write increment and a read increment fall in the same cycle, it adds 2, still saturating.
- `io_wr_en` is honoured in every FSM state. If a write and RD_ACK entry hit the same register in the same cycle, the read returns the pre-write value.
- `res` mid-operation:
  - FSM returns to IDLE and any pending ack is dropped.
  - All outputs and registers take their reset values.

## Timing
- Reset values:
  - `io_rd_ack`=0, `ipb_rdata`=0;
  - `ctrl_out`=0, `pulse_out`=0;
  - scratch=0, `bad_addr_cnt`=0;
  - FSM=IDLE.
- Read latency: if `io_rd_en` first rises in cycle T, `io_rd_ack` is high in cycle T+`RD_LATENCY` only.
- `ipb_rdata` is valid from the ack cycle and held until the next ack or `res`.
- Write latency: a register written in cycle T is visible on its output, and on readback, from cycle T+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `IPB_IO_REGBANK_STATUS_SYNC_EN`:
  - Defined: each `status_in` word passes through a 2-flop synchroniser (reset to 0) before decode, adding 2 cycles of status-to-readback delay.
  - Undefined: `status_in` is sampled directly at the RD_ACK load edge.
  - Read ack latency is identical in both builds.

## Test plan
- Reset, then read 0x0 with `RD_LATENCY`=2: `io_rd_en` rises at T → `io_rd_ack` at T+2 only, `ipb_rdata`=32'h5746_4435.
- Write 0x2 with 32'hA5A5_0001 → `ctrl_out`=32'hA5A5_0001 next cycle. A subsequent read of 0x2 returns the same value.
- Write 0x3 with 32'h0000_0081 → `pulse_out`=32'h81 for exactly one cycle, then 0. A read of 0x3 returns 0.
- Read 0xC, then write 0xF → `ipb_rdata`=32'hDEAD_BEEF and `bad_addr_cnt`=2. A read of 0x8 returns 32'h0000_0002.
- Abort and reset mid-operation:
  - Drop `io_rd_en` one cycle after it rises → no ack, `ipb_rdata` unchanged.
  - Assert `res` in RD_WAIT → no ack, all outputs return to reset values.
- Saturation: preload 65535 unmapped accesses, then perform simultaneous unmapped write and read-ack → `bad_addr_cnt` stays 16'hFFFF.
